// File: rtl/chdr_pkg.sv
// Shared CHDR definitions: field positions, packer FSM states, sample widths.
package chdr_pkg;

  localparam int unsigned ChdrW      = 64;
  localparam int unsigned HasTimeBit = 61;
  localparam int unsigned LenMsb     = 47;
  localparam int unsigned LenLsb     = 32;
  localparam int unsigned SidMsb     = 31;
  localparam int unsigned SidDstMsb  = 15;

  localparam int unsigned Sc16W      = 16;
  localparam int unsigned Sc12W      = 12;
  localparam int unsigned Sc12SampW  = 2 * Sc12W;

  typedef enum logic [1:0] {
    StHdr,
    StTime,
    StBody,
    StFlush
  } chdr_state_e;

  // Header size in bytes, selected by the has_time flag.
  function automatic logic [15:0] chdr_hdr_bytes(input logic has_time);
    return has_time ? 16'd16 : 16'd8;
  endfunction

  // Length of the sc12 packet: header plus 3 bytes per complete sc16 sample.
  function automatic logic [15:0] sc12_len(input logic [15:0] len16, input logic has_time);
    logic [15:0] hdr_bytes;
    logic [15:0] pay_bytes;
    hdr_bytes = chdr_hdr_bytes(has_time);
    pay_bytes = len16 - hdr_bytes;
    return 16'(hdr_bytes + 16'(3 * {2'b00, pay_bytes[15:2]}));
  endfunction

endpackage

// File: rtl/sc16_to_sc12_round.sv
// Round-half-up one 16-bit component to 12 bits, saturating at the positive limit.
module sc16_to_sc12_round
  import chdr_pkg::*;
(
  input  logic [Sc16W-1:0] x16,
  output logic [Sc12W-1:0] x12
);

  logic [Sc12W-1:0] trunc;
  logic             half;
  logic             unused_lsbs;

  assign trunc       = x16[Sc16W-1:Sc16W-Sc12W];
  assign half        = x16[Sc16W-Sc12W-1];
  assign unused_lsbs = ^x16[Sc16W-Sc12W-2:0];

  // Only the largest positive value can overflow when rounding up.
  always_comb begin
    if (trunc == 12'h7FF && half) begin
      x12 = 12'h7FF;
    end else begin
      x12 = trunc + {{(Sc12W-1){1'b0}}, half};
    end
  end

endmodule

// File: rtl/chdr_16sc_to_12sc.sv
// Packs CHDR sc16 payloads into contiguous sc12 samples (4 input lines -> 3 output lines),
// rewrites the length field and optionally the SID destination.
module chdr_16sc_to_12sc
  import chdr_pkg::*;
#(
  parameter int unsigned BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  localparam logic [7:0] BaseAddr = 8'(BASE);

  chdr_state_e state_q, state_d;

  logic [16:0]      ctrl_q;
  logic             odd_q, odd_d;
  logic [ChdrW-1:0] res_q, res_d;
  logic [6:0]       rbits_q, rbits_d;
  logic [ChdrW-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic out_free;
  logic in_xfer;
  logic unused_set;

  assign unused_set = ^set_data[31:17];

  assign out_free = o_tready | ~out_valid_q;
  assign i_tready = out_free & (state_q != StFlush);
  assign in_xfer  = i_tvalid & i_tready;

  // Header rewrite
  logic             has_time;
  logic [15:0]      len_in;
  logic [15:0]      pay_bytes;
  logic [15:0]      dst;
  logic [ChdrW-1:0] hdr_out;

  assign has_time  = i_tdata[HasTimeBit];
  assign len_in    = i_tdata[LenMsb:LenLsb];
  assign pay_bytes = len_in - chdr_hdr_bytes(has_time);
  assign dst       = ctrl_q[16] ? ctrl_q[15:0] : i_tdata[SidDstMsb:0];
  assign hdr_out   = {i_tdata[63:LenMsb+1], sc12_len(len_in, has_time),
                      i_tdata[SidMsb:SidDstMsb+1], dst};

  // Sample conversion
  logic [Sc12W-1:0] i0, q0, i1, q1;

  sc16_to_sc12_round u_round_i0 (.x16(i_tdata[63:48]), .x12(i0));
  sc16_to_sc12_round u_round_q0 (.x16(i_tdata[47:32]), .x12(q0));
  sc16_to_sc12_round u_round_i1 (.x16(i_tdata[31:16]), .x12(i1));
  sc16_to_sc12_round u_round_q1 (.x16(i_tdata[15:0]),  .x12(q1));

  // Gearbox: residue is left-aligned, bits below rbits_q are always zero.
  logic                   last_odd;
  logic [6:0]             add_bits;
  logic [6:0]             total_bits;
  logic [2*Sc12SampW-1:0] new_bits;
  logic [2*ChdrW-1:0]     acc;

  assign last_odd   = i_tlast & odd_q;
  assign add_bits   = last_odd ? 7'd24 : 7'd48;
  assign new_bits   = last_odd ? {i0, q0, {Sc12SampW{1'b0}}} : {i0, q0, i1, q1};
  assign total_bits = rbits_q + add_bits;
  assign acc        = {res_q, {ChdrW{1'b0}}} | ({new_bits, 80'd0} >> rbits_q);

  // Settings register; the header samples it, so mid-packet writes affect later packets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else if (set_stb && set_addr == BaseAddr) begin
      ctrl_q <= set_data[16:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StHdr;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; input tlast always terminates the packet.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (in_xfer) begin
          if (i_tlast)       state_d = StHdr;
          else if (has_time) state_d = StTime;
          else               state_d = StBody;
        end
      end
      StTime: begin
        if (in_xfer) state_d = i_tlast ? StHdr : StBody;
      end
      StBody: begin
        if (in_xfer && i_tlast) state_d = (total_bits > 7'd64) ? StFlush : StHdr;
      end
      StFlush: begin
        if (out_free) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  // Output register and gearbox next-state
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~o_tready;
    res_d       = res_q;
    rbits_d     = rbits_q;
    odd_d       = odd_q;
    unique case (state_q)
      StHdr: begin
        if (in_xfer) begin
          out_data_d  = hdr_out;
          out_last_d  = i_tlast;
          out_valid_d = 1'b1;
          odd_d       = pay_bytes[2];
          res_d       = '0;
          rbits_d     = '0;
        end
      end
      StTime: begin
        if (in_xfer) begin
          out_data_d  = i_tdata;
          out_last_d  = i_tlast;
          out_valid_d = 1'b1;
        end
      end
      StBody: begin
        if (in_xfer) begin
          if (i_tlast || total_bits >= 7'd64) begin
            out_data_d  = acc[2*ChdrW-1:ChdrW];
            out_valid_d = 1'b1;
            if (total_bits > 7'd64) begin
              out_last_d = 1'b0;
              res_d      = acc[ChdrW-1:0];
              rbits_d    = total_bits - 7'd64;
            end else begin
              out_last_d = i_tlast;
              res_d      = acc[ChdrW-1:0];
              rbits_d    = '0;
            end
          end else begin
            res_d   = acc[2*ChdrW-1:ChdrW];
            rbits_d = total_bits;
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          out_data_d  = res_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          res_d       = '0;
          rbits_d     = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      rbits_q     <= '0;
      odd_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      rbits_q     <= rbits_d;
      odd_q       <= odd_d;
    end
  end

  assign o_tdata  = out_data_q;
  assign o_tlast  = out_last_q;
  assign o_tvalid = out_valid_q;

endmodule

// File: tb/tb_chdr_16sc_to_12sc.sv
// Scoreboard bench for chdr_16sc_to_12sc with a bit-list reference model.
module tb_chdr_16sc_to_12sc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [63:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;

  chdr_16sc_to_12sc dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    exp_lines_q[$];
  beat_t cap_q[$];
  beat_t ref_q[$];

  int checks = 0;
  int errors = 0;
  logic ignore_out = 1'b0;
  logic capture = 1'b0;
  logic bp_en = 1'b0;
  logic gap_en = 1'b1;
  logic cnt_en = 1'b0;
  int   low_cnt = 0;

  // Reference view of the settings register
  logic        rw_m = 1'b0;
  logic [15:0] dest_m = '0;

  // Current packet content
  logic        pk_time;
  int          pk_n;
  logic [15:0] pk_flags;
  logic [31:0] pk_sid;
  logic [63:0] pk_ts;
  logic [15:0] pk_comp[$];

  beat_t mon_e;
  int    line_cnt = 0;
  int    mon_lines;

  // Monitor: compares every accepted output beat against the scoreboard
  always @(negedge clk) begin
    if (reset && o_tvalid && o_tready && !ignore_out) begin
      if (capture) cap_q.push_back({o_tlast, o_tdata});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected: got last=%0b data=%h, want none", o_tlast, o_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e !== {o_tlast, o_tdata}) begin
          errors++;
          $display("FAIL out_beat: got last=%0b data=%h, want last=%0b data=%h",
                   o_tlast, o_tdata, mon_e.last, mon_e.data);
        end
      end
      line_cnt++;
      if (o_tlast) begin
        checks++;
        mon_lines = (exp_lines_q.size() != 0) ? exp_lines_q.pop_front() : -1;
        if (line_cnt != mon_lines) begin
          errors++;
          $display("FAIL line_count: got %0d, want %0d", line_cnt, mon_lines);
        end
        line_cnt = 0;
      end
    end
  end

  always @(negedge clk) if (cnt_en && !i_tready) low_cnt++;

  // Output backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [11:0] rnd12(input logic [15:0] x);
    int v;
    v = $signed(x);
    v = (v + 8) >>> 4;
    if (v > 2047) v = 2047;
    return v[11:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Present one beat; all drive tasks enter and leave just after a rising edge.
  task automatic drive_beat(input logic [63:0] d, input logic l);
    int  guard;
    logic acc;
    guard = 0;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    i_tdata = d;
    i_tlast = l;
    i_tvalid = 1'b1;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 500) begin
        checks++;
        errors++;
        $display("FAIL input_stall: got i_tready stuck 0, want accept within 500 cycles");
        acc = 1'b1;
      end
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic write_set(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (a == 8'd0) begin
      rw_m = d[16];
      dest_m = d[15:0];
    end
  endtask

  task automatic gen_packet(input logic t, input int n);
    logic [15:0] corner[5];
    corner[0] = 16'h7FF8; corner[1] = 16'h7FF7; corner[2] = 16'h8000;
    corner[3] = 16'hFFF8; corner[4] = 16'h0008;
    pk_time = t;
    pk_n = n;
    pk_flags = 16'($urandom);
    pk_sid = $urandom;
    pk_ts = {$urandom, $urandom};
    pk_comp.delete();
    for (int i = 0; i < 2 * n; i++) begin
      if ($urandom_range(0, 5) == 0) pk_comp.push_back(corner[$urandom_range(0, 4)]);
      else pk_comp.push_back(16'($urandom));
    end
  endtask

  // Push the model's expected output for the current packet, then drive it.
  task automatic run_packet();
    logic [63:0] hdr, w;
    logic [15:0] len_in, len_out, dst;
    logic [11:0] c12;
    bit          bits[$];
    int          hb, nb, nlines, idx;
    hb = pk_time ? 16 : 8;
    len_in = 16'(hb + 4 * pk_n);
    len_out = 16'(hb + 3 * pk_n);
    dst = rw_m ? dest_m : pk_sid[15:0];
    hdr = {pk_flags[15:14], pk_time, pk_flags[12:0], len_in, pk_sid};
    exp_q.push_back({(pk_n == 0) && !pk_time, pk_flags[15:14], pk_time, pk_flags[12:0],
                     len_out, pk_sid[31:16], dst});
    if (pk_time) exp_q.push_back({pk_n == 0, pk_ts});
    for (int i = 0; i < pk_comp.size(); i++) begin
      c12 = rnd12(pk_comp[i]);
      for (int b = 11; b >= 0; b--) bits.push_back(c12[b]);
    end
    nlines = (bits.size() + 63) / 64;
    for (int l = 0; l < nlines; l++) begin
      w = '0;
      for (int b = 0; b < 64; b++) begin
        idx = l * 64 + b;
        if (idx < bits.size()) w[63-b] = bits[idx];
      end
      exp_q.push_back({l == nlines - 1, w});
    end
    exp_lines_q.push_back(1 + int'(pk_time) + nlines);

    drive_beat(hdr, (pk_n == 0) && !pk_time);
    if (pk_time) drive_beat(pk_ts, pk_n == 0);
    nb = (pk_n + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      w[63:48] = pk_comp[4*k];
      w[47:32] = pk_comp[4*k+1];
      w[31:16] = (4*k+2 < pk_comp.size()) ? pk_comp[4*k+2] : 16'($urandom);
      w[15:0]  = (4*k+3 < pk_comp.size()) ? pk_comp[4*k+3] : 16'($urandom);
      drive_beat(w, k == nb - 1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 64'(o_tvalid), 64'd0);
    check("reset_tlast", 64'(o_tlast), 64'd0);
    check("reset_tdata", o_tdata, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_tready", 64'(i_tready), 64'd1);

    // Directed packet with timestamp and fixed expected words
    exp_q.push_back({1'b0, 64'h2000_001C_DEAD_BEEF});
    exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    exp_q.push_back({1'b0, 64'h1234_5678_ABCE_0010});
    exp_q.push_back({1'b1, 64'h007F_F800_0000_0000});
    exp_lines_q.push_back(4);
    drive_beat(64'h2000_0020_DEAD_BEEF, 1'b0);
    drive_beat(64'h0123_4567_89AB_CDEF, 1'b0);
    drive_beat(64'h1230_4560_789A_BCDE, 1'b0);
    drive_beat(64'h0010_FFF8_7FF8_8000, 1'b1);
    drain();

    // Rounding corners: 7FF7->7FF, 0018->002, FFF8->000, 8000->800
    exp_q.push_back({1'b0, 64'h0000_000E_0102_0304});
    exp_q.push_back({1'b1, 64'h7FF0_0200_0800_0000});
    exp_lines_q.push_back(2);
    drive_beat(64'h0000_0010_0102_0304, 1'b0);
    drive_beat(64'h7FF7_0018_FFF8_8000, 1'b1);
    drain();

    // SID rewrite; a write to another address must be ignored
    write_set(8'd0, 32'h0001_FEED);
    write_set(8'd1, 32'h0001_1111);
    for (int n = 1; n <= 9; n++) begin
      gen_packet(1'b1, n);
      pk_sid = 32'hDEAD_BEEF;
      run_packet();
    end
    drain();
    write_set(8'd0, 32'h0000_0000);

    // 8 samples: residue returns to zero, no flush cycle
    gap_en = 1'b0;
    low_cnt = 0;
    cnt_en = 1'b1;
    gen_packet(1'b0, 8);
    run_packet();
    drain();
    cnt_en = 1'b0;
    check("flush_cycles_8", 64'(low_cnt), 64'd0);

    // 6 samples: one flush cycle with i_tready low
    low_cnt = 0;
    cnt_en = 1'b1;
    gen_packet(1'b0, 6);
    run_packet();
    drain();
    cnt_en = 1'b0;
    check("flush_cycles_6", 64'(low_cnt), 64'd1);
    gap_en = 1'b1;

    // Random packets, including empty ones
    for (int p = 0; p < 24; p++) begin
      gen_packet(1'($urandom_range(0, 1)), $urandom_range(0, 20));
      run_packet();
    end
    drain();

    // Same 27-sample packet without and with output backpressure
    gen_packet(1'b1, 27);
    capture = 1'b1;
    run_packet();
    drain();
    ref_q = cap_q;
    cap_q.delete();
    bp_en = 1'b1;
    run_packet();
    drain();
    bp_en = 1'b0;
    capture = 1'b0;
    check("bp_beat_count", 64'(cap_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++) begin
      check("bp_beat", cap_q[i].data, ref_q[i].data);
    end

    // Reset in the middle of a body; control register must clear too
    write_set(8'd0, 32'h0001_ABCD);
    gen_packet(1'b0, 10);
    ignore_out = 1'b1;
    gap_en = 1'b0;
    drive_beat({pk_flags[15:14], 1'b0, pk_flags[12:0], 16'd48, pk_sid}, 1'b0);
    drive_beat({pk_comp[0], pk_comp[1], pk_comp[2], pk_comp[3]}, 1'b0);
    drive_beat({pk_comp[4], pk_comp[5], pk_comp[6], pk_comp[7]}, 1'b0);
    reset = 1'b0;
    #1;
    check("midreset_tvalid", 64'(o_tvalid), 64'd0);
    rw_m = 1'b0;
    dest_m = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ignore_out = 1'b0;
    line_cnt = 0;
    gap_en = 1'b1;
    gen_packet(1'b1, 5);
    run_packet();
    gen_packet(1'b0, 3);
    run_packet();
    drain();
    check("lines_outstanding", 64'(exp_lines_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chdr_16sc_to_12sc.md
Name: chdr_16sc_to_12sc

Overview:
- Packs CHDR data packets carrying 16-bit complex samples (sc16) into 12-bit complex samples (sc12) for the narrow transport path.
- Four sc16 payload lines become three sc12 payload lines; the CHDR length field is recomputed to match.
- Optionally rewrites the SID destination from a settings register.
- Sits on the transmit side of the link; the matching chdr_12sc_to_16sc block unpacks the same stream at the far end.

Parameters:
- BASE, 0, settings-bus address of the control register.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data; [16] enable SID rewrite, [15:0] new destination
- i_tdata  in  64  input CHDR (sc16)
- i_tlast  in  1  input end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  64  output CHDR (sc12)
- o_tlast  out  1  output end of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Behaviour:
- Reset (reset low, async):
  - state=HDR, o_tvalid=0, o_tlast=0, o_tdata=0, residue empty.
  - Control register cleared (rewrite disabled, dest=0).
  - Reset mid-packet drops the partial packet. After reset, the next input beat is treated as a header.
- Settings: on set_stb with set_addr==BASE, latch set_data[16:0] next cycle. The value is sampled at each header beat, so a mid-packet write affects only later packets.
- Handshake:
  - One registered output stage. i_tready = (o_tready | ~o_tvalid) & (state!=FLUSH).
  - A transfer occurs on valid&ready. o_tdata/o_tlast stay stable while o_tvalid & ~o_tready.
- Header handling (states HDR -> [TIME] -> BODY -> [FLUSH] -> HDR):
  - Header bit 61 = has_time; hdr_bytes = 16 if set, else 8. Payload bytes P = len[47:32] - hdr_bytes; sample count N = P/4.
  - Output len = hdr_bytes + 3N, 16-bit, wraps modulo 2^16.
  - Bits [63:48] pass through. SID[31:16] passes; SID[15:0] = dest if enabled, else unchanged.
  - HDR emits the header in one cycle. The TIME state passes the timestamp beat unchanged.
  - If N==0, the header or timestamp beat carries tlast and state returns to HDR.
- Sample format:
  - Input line: sample0 in [63:32] (I [63:48], Q [47:32]), sample1 in [31:0].
  - Each component x16 -> x12 = x16[15:4] + x16[3], round half up. Saturate to 0x7FF when x16[15:4]==0x7FF and x16[3]==1. Negative values never overflow.
  - sc12 sample = {I12,Q12}, 24 bits, packed MSB-first contiguously across lines.
- Gearbox (BODY):
  - Residue register of up to 56 bits plus a count r in bits.
  - Each input beat appends 48 bits (24 if the beat is the last and N is odd; sample1 is ignored).
  - If r+add >= 64, emit the top 64 bits and set r -= 64-add; otherwise accumulate with no output. Steady cycle r = 0, 48, 32, 16, 0, giving 4 in -> 3 out.
- End of packet (input tlast):
  - If the remaining bits are 1..64, emit them left-aligned and zero-padded with tlast.
  - If they exceed 64 (r+add = 72, 80 or 96), emit 64 bits without tlast, go to FLUSH, hold i_tready=0, then emit the remainder zero-padded with tlast.
  - Output line count = ceil(3N/8) + header lines.
- Malformed input (tlast earlier or later than len implies): tlast is authoritative and packing ends there; the length field is not corrected.
- Latency: 1 cycle from input beat to output register when no accumulate-only beat is involved.

Decomposition:
- Shared package (chdr_pkg): CHDR field positions (has_time bit 61, len [47:32], SID [31:0]), HDR/TIME/BODY/FLUSH state encoding, and the sc12/sc16 width constants.
- Sub-module sc16_to_sc12_round: combinational round/saturate of one 16-bit component, instantiated 4x. Reused by future sc16->sc12 blocks.

Test Plan:
- Packet, has_time=1, len=32 (4 samples), words 0x1230_4560_789A_BCDE, 0x0010_FFF8_7FF8_8000, rewrite off, SID 0xDEADBEEF:
  - Header len 28.
  - Payload 0x123456_78A_BCE_001 (continued) in 2 lines, last line zero-padded, tlast on line 2.
  - SID unchanged.
- Rewrite enabled, dest 0xFEED, payload lengths 3..27 bytes in steps of 3 → SID=0xDEADFEED, len=16+3*(P/4), line count ceil(3N/8)+2, tlast only on the final line.
- 8-sample packet (r returns to 0) and 6-sample packet (FLUSH path) → 3 and 3 payload lines respectively; in the 6-sample case i_tready is low exactly one cycle in FLUSH.
- Rounding and saturation:
  - 0x7FF8 -> 0x7FF.
  - 0x7FF7 -> 0x7FF.
  - 0x0018 -> 0x002.
  - 0xFFF8 -> 0x000.
  - 0x8000 -> 0x800.
- Random o_tready backpressure (50%) on a 27-sample packet → output identical to the no-backpressure run, no beat lost or duplicated.
- Reset asserted mid-BODY → o_tvalid=0 immediately. The next packet is converted correctly from its header.
